// File: rtl/fact_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fact_pkg
// Description : Shared encodings for the iterative factorial accelerator.
// Revision    : 1.0 - initial release
// ============================================================================
package fact_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Word offsets within the accelerator window
    localparam logic [2:0] c_ADDR_N      = 3'd0;
    localparam logic [2:0] c_ADDR_RES_LO = 3'd1;
    localparam logic [2:0] c_ADDR_RES_HI = 3'd2;
    localparam logic [2:0] c_ADDR_STATUS = 3'd3;
    localparam logic [2:0] c_ADDR_CTRL   = 3'd4;
    localparam logic [2:0] c_ADDR_CYCLES = 3'd5;

    localparam int c_STAT_DONE = 0;
    localparam int c_STAT_OVF  = 1;
    localparam int c_STAT_BUSY = 2;

    localparam int c_CTRL_GO     = 0;
    localparam int c_CTRL_ABORT  = 1;
    localparam int c_CTRL_IRQ_EN = 2;
    localparam int c_CTRL_CLEAR  = 3;

endpackage : fact_pkg
`default_nettype wire

// File: rtl/fact_mul_ovf.sv
`default_nettype none
// ============================================================================
// Module      : fact_mul_ovf
// Description : Combinational WIDTH x CNT_W multiply with overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fact_mul_ovf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [CNT_W-1:0] i_k,
    output logic [WIDTH-1:0] o_prod,
    output logic             o_ovf
);

    logic [WIDTH+CNT_W-1:0] w_full;

    assign w_full = {{CNT_W{1'b0}}, i_acc} * {{WIDTH{1'b0}}, i_k};
    assign o_prod = w_full[WIDTH-1:0];
    // Any bit above the result width means the product no longer fits
    assign o_ovf  = |w_full[WIDTH+CNT_W-1:WIDTH];

endmodule : fact_mul_ovf
`default_nettype wire

// File: rtl/factorial_accel_iter.sv
`default_nettype none
// ============================================================================
// Module      : factorial_accel_iter
// Description : MMIO iterative n! accelerator, one multiply per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module factorial_accel_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       addr,
    input  logic [31:0]      din,
    input  logic             we,
    output logic [31:0]      dout,
    output logic             busy,
    output logic             done,
    output logic             irq,
    output logic [WIDTH-1:0] result
);

    import fact_pkg::*;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_n;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_k;
    logic [CNT_W-1:0]   r_cyc;
    logic [CNT_W-1:0]   r_cycles;
    logic [WIDTH-1:0]   r_result;
    logic               r_done;
    logic               r_ovf;
    logic               r_busy;
    logic               r_irq_en;

    logic               w_wr_n;
    logic               w_wr_ctrl;
    logic               w_go;
    logic               w_abort;
    logic               w_clear;
    logic               w_k_last;
    logic               w_small_n;
    logic [WIDTH-1:0]   w_prod;
    logic               w_mul_ovf;
    logic [63:0]        w_res_ext;
    logic [31:0]        w_status;
    logic [31:0]        w_ctrl_rd;

    assign w_wr_n    = we && (addr == c_ADDR_N) && !r_busy;
    assign w_wr_ctrl = we && (addr == c_ADDR_CTRL);
    // Abort takes precedence over a simultaneous go
    assign w_abort   = w_wr_ctrl && din[c_CTRL_ABORT];
    assign w_go      = w_wr_ctrl && din[c_CTRL_GO] && !din[c_CTRL_ABORT];
    assign w_clear   = w_wr_ctrl && din[c_CTRL_CLEAR];
    assign w_k_last  = (32'(r_k) == r_n);
    assign w_small_n = (r_n <= 32'd1);

    fact_mul_ovf #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .i_acc  (r_acc),
        .i_k    (r_k),
        .o_prod (w_prod),
        .o_ovf  (w_mul_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_state_nxt = w_small_n ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_mul_ovf || w_k_last) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n      <= '0;
            r_acc    <= WIDTH'(1);
            r_k      <= '0;
            r_cyc    <= '0;
            r_cycles <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_wr_n) begin
                r_n <= din;
            end
            if (w_wr_ctrl) begin
                r_irq_en <= din[c_CTRL_IRQ_EN];
            end
            if (w_clear) begin
                r_done <= 1'b0;
                r_ovf  <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_done <= 1'b0;
                        r_ovf  <= 1'b0;
                        r_acc  <= WIDTH'(1);
                        r_k    <= CNT_W'(2);
                        r_cyc  <= '0;
                        r_busy <= !w_small_n;
                    end
                end
                ST_RUN: begin
                    if (w_abort) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b0;
                        r_ovf  <= 1'b0;
                    end else begin
                        if (r_cyc != '1) begin
                            r_cyc <= r_cyc + 1'b1;
                        end
                        if (w_mul_ovf) begin
                            r_ovf    <= 1'b1;
                            r_result <= '0;
                        end else begin
                            r_acc <= w_prod;
                            if (!w_k_last) begin
                                r_k <= r_k + 1'b1;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    if (!r_ovf) begin
                        r_result <= r_acc;
                    end
                    r_done   <= 1'b1;
                    r_cycles <= r_cyc;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Zero-extension to 64 bits makes RES_HI read 0 for narrow results
    assign w_res_ext = 64'(r_result);

    always_comb begin
        w_status              = '0;
        w_status[c_STAT_DONE] = r_done;
        w_status[c_STAT_OVF]  = r_ovf;
        w_status[c_STAT_BUSY] = r_busy;
        w_ctrl_rd                 = '0;
        w_ctrl_rd[c_CTRL_IRQ_EN]  = r_irq_en;
    end

    always_comb begin
        dout = '0;
        case (addr)
            c_ADDR_N:      dout = r_n;
            c_ADDR_RES_LO: dout = w_res_ext[31:0];
            c_ADDR_RES_HI: dout = w_res_ext[63:32];
            c_ADDR_STATUS: dout = w_status;
            c_ADDR_CTRL:   dout = w_ctrl_rd;
            c_ADDR_CYCLES: dout = 32'(r_cycles);
            default:       dout = '0;
        endcase
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign irq    = r_done && r_irq_en;
    assign result = r_result;

endmodule : factorial_accel_iter
`default_nettype wire

// File: tb/tb_factorial_accel_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_factorial_accel_iter
// Description : Directed bench driving a 32-bit and a 64-bit instance in step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_factorial_accel_iter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  addr;
    logic [31:0] din;
    logic        we;

    logic [31:0] dout32, dout64;
    logic        busy32, done32, irq32;
    logic        busy64, done64, irq64;
    logic [31:0] result32;
    logic [63:0] result64;

    int total  = 0;
    int passes = 0;
    logic [31:0] v32, v64;
    int          lat;

    always #5 clk = ~clk;

    factorial_accel_iter #(.WIDTH(32), .CNT_W(8)) u_d32 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .we(we),
        .dout(dout32), .busy(busy32), .done(done32), .irq(irq32), .result(result32)
    );

    factorial_accel_iter #(.WIDTH(64), .CNT_W(8)) u_d64 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .we(we),
        .dout(dout64), .busy(busy64), .done(done64), .irq(irq64), .result(result64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] o32, output logic [31:0] o64);
        @(negedge clk);
        addr = a;
        #1;
        o32 = dout32;
        o64 = dout64;
    endtask

    // Counts negedges after the go edge until done rises, bounded by max
    task automatic wait_done(input bit use64, input int max, output int n);
        n = 0;
        while (((use64 ? done64 : done32) !== 1'b1) && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        addr    = 3'd0;
        din     = 32'd0;
        we      = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_outs32", {busy32, done32, irq32, result32}, '0);
        chk("rst_outs64", {busy64, done64, irq64, result64}, '0);
        reset_n = 1'b1;
        rd(3'd3, v32, v64);
        chk("rst_status", {v32, v64}, '0);

        // 5! : busy for exactly five cycles
        wr(3'd0, 32'd5);
        wr(3'd4, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t1_busy_c%0d", i), {busy32, done32, busy64, done64}, 4'b1010);
            @(negedge clk);
        end
        chk("t1_done", {busy32, done32, busy64, done64}, 4'b0101);
        chk("t1_irq_gated", {irq32, irq64}, 2'b00);
        rd(3'd1, v32, v64);
        chk("t1_res_lo", {v32, v64}, {32'd120, 32'd120});
        rd(3'd2, v32, v64);
        chk("t1_res_hi", {v32, v64}, '0);
        rd(3'd3, v32, v64);
        chk("t1_status", {v32, v64}, {32'h1, 32'h1});
        rd(3'd5, v32, v64);
        chk("t1_cycles", {v32, v64}, {32'd4, 32'd4});

        // N=0 and N=1: FIN directly; go clears the previous done
        for (int n = 0; n < 2; n++) begin
            wr(3'd0, 32'(n));
            wr(3'd4, 32'd1);
            chk($sformatf("t2_n%0d_done_clr", n), {busy32, done32}, 2'b00);
            @(negedge clk);
            chk($sformatf("t2_n%0d_done", n), {busy32, done32}, 2'b01);
            rd(3'd1, v32, v64);
            chk($sformatf("t2_n%0d_res", n), v32, 32'd1);
            rd(3'd5, v32, v64);
            chk($sformatf("t2_n%0d_cyc", n), v32, 32'd0);
        end

        // 12! fits in 32 bits
        wr(3'd0, 32'd12);
        wr(3'd4, 32'd1);
        wait_done(1'b0, 40, lat);
        chk("t3_n12_lat", 32'(lat), 32'd12);
        rd(3'd1, v32, v64);
        chk("t3_n12_res", v32, 32'd479001600);
        rd(3'd3, v32, v64);
        chk("t3_n12_status", v32, 32'h1);
        rd(3'd5, v32, v64);
        chk("t3_n12_cyc", v32, 32'd11);

        // 13! overflows 32 bits, fits 64
        wr(3'd0, 32'd13);
        wr(3'd4, 32'd1);
        wait_done(1'b0, 40, lat);
        chk("t3_n13_lat", 32'(lat), 32'd13);
        rd(3'd3, v32, v64);
        chk("t3_n13_status", {v32, v64}, {32'h3, 32'h1});
        rd(3'd1, v32, v64);
        chk("t3_n13_res_lo", {v32, v64}, {32'h0, 32'h7328CC00});
        rd(3'd2, v32, v64);
        chk("t3_n13_res_hi", v64, 32'h1);
        rd(3'd5, v32, v64);
        chk("t3_n13_cyc", v32, 32'd12);

        // 20! fits 64 bits
        wr(3'd0, 32'd20);
        wr(3'd4, 32'd1);
        wait_done(1'b1, 40, lat);
        chk("t4_n20_lat", 32'(lat), 32'd20);
        chk("t4_n20_result", result64, 64'h21C3677C82B40000);
        rd(3'd2, v32, v64);
        chk("t4_n20_res_hi", v64, 32'h21C3677C);
        rd(3'd1, v32, v64);
        chk("t4_n20_res_lo", v64, 32'h82B40000);
        rd(3'd3, v32, v64);
        chk("t4_n20_status", {v32, v64}, {32'h3, 32'h1});

        // 21! overflows 64 bits
        wr(3'd0, 32'd21);
        wr(3'd4, 32'd1);
        wait_done(1'b1, 40, lat);
        chk("t4_n21_lat", 32'(lat), 32'd21);
        rd(3'd3, v32, v64);
        chk("t4_n21_status", v64, 32'h3);
        chk("t4_n21_result", result64, 64'h0);
        rd(3'd5, v32, v64);
        chk("t4_n21_cyc", v64, 32'd20);

        // Non-zero baseline result before the abort test
        wr(3'd0, 32'd4);
        wr(3'd4, 32'd1);
        wait_done(1'b0, 40, lat);
        chk("t5_pre_res", {result32, result64}, {32'd24, 64'd24});

        // Abort mid-run; N write while busy is ignored
        wr(3'd0, 32'd10);
        wr(3'd4, 32'd1);
        wr(3'd0, 32'd7);
        wr(3'd4, 32'd2);
        chk("t5_abort_outs", {busy32, done32, busy64, done64}, 4'b0000);
        rd(3'd3, v32, v64);
        chk("t5_abort_status", {v32, v64}, '0);
        rd(3'd1, v32, v64);
        chk("t5_abort_res_hold", {v32, v64}, {32'd24, 32'd24});
        rd(3'd5, v32, v64);
        chk("t5_abort_cyc_hold", {v32, v64}, {32'd3, 32'd3});
        rd(3'd0, v32, v64);
        chk("t5_n_write_ignored", {v32, v64}, {32'd10, 32'd10});

        // go together with abort in IDLE does nothing
        wr(3'd4, 32'd3);
        chk("t5_go_abort_idle", {busy32, done32}, 2'b00);
        @(negedge clk);
        chk("t5_go_abort_stays", {busy32, done32}, 2'b00);

        // Interrupt with enable, then clear
        wr(3'd0, 32'd3);
        wr(3'd4, 32'd5);
        wait_done(1'b0, 40, lat);
        chk("t6_irq", {irq32, irq64}, 2'b11);
        rd(3'd1, v32, v64);
        chk("t6_res", v32, 32'd6);
        rd(3'd4, v32, v64);
        chk("t6_ctrl_rd", v32, 32'h4);
        wr(3'd4, 32'd12);
        chk("t6_clear", {irq32, done32, irq64, done64}, 4'b0000);

        // Asynchronous reset mid-run
        wr(3'd0, 32'd9);
        wr(3'd4, 32'd5);
        repeat (3) @(negedge clk);
        chk("t6_running", {busy32, busy64}, 2'b11);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_outs32", {busy32, done32, irq32, result32}, '0);
        chk("t6_rst_outs64", {busy64, done64, irq64, result64}, '0);
        rd(3'd0, v32, v64);
        chk("t6_rst_n_reg", {v32, v64}, '0);
        rd(3'd4, v32, v64);
        chk("t6_rst_ctrl", {v32, v64}, '0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule : tb_factorial_accel_iter
`default_nettype wire
